eth_rx_buf_writer: RTL and testbench

- Upstream fill stage of the RX frame buffer, in the byte-write clock domain.
- Accepts the byte-wide AXI-Stream from the RX MAC and writes each byte into the 2 KiB RX buffer (write port: 8-bit data, 11-bit byte address).
- Tracks free space against the reader's pointer and drops errored, oversize or overflowing frames.
- For each good frame, posts a start/length descriptor to the downstream word reader.

---
 rtl/eth_rx_pkg.sv | 22 ++
 rtl/eth_rx_buf_writer.sv | 168 ++++++++++++++++
 tb/tb_eth_rx_buf_writer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/eth_rx_pkg.sv
// Shared types for the RX frame buffer: pointer width, writer FSM states and the
// start/length descriptor handed from the byte writer to the word reader.
package eth_rx_pkg;

   localparam int RX_BUF_AW    = 11;
   localparam int RX_FCS_BYTES = 4;

   typedef logic [RX_BUF_AW:0] rx_ptr_t;

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      DROP,
      POST
   } rx_wr_state_e;

   typedef struct packed {
      logic [RX_BUF_AW-1:0] start;
      rx_ptr_t              len;
   } rx_desc_t;

endpackage

// File: rtl/eth_rx_buf_writer.sv
// RX buffer fill stage: writes MAC stream bytes into the 2 KiB buffer, drops bad
// frames and posts descriptors. Optional RX_FCS_STRIP_EN reports length minus FCS.
//
// state | meaning
// IDLE  | waiting for first beat of a frame
// WRITE | storing frame bytes
// DROP  | discarding rest of an overflowing/oversize frame
// POST  | descriptor offered, input stalled until taken
module eth_rx_buf_writer
   import eth_rx_pkg::*;
#(
   parameter int BUF_BYTES     = 2048,
   parameter int MAX_FRAME_LEN = 1518,
   parameter int DROP_CNT_W    = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic [7:0]             s_tdata_i,
   input  logic                   s_tvalid_i,
   input  logic                   s_tlast_i,
   input  logic                   s_tuser_i,
   output logic                   s_tready_o,
   input  rx_ptr_t                rd_ptr_i,
   output logic                   mem_en_o,
   output logic                   mem_we_o,
   output logic [RX_BUF_AW-1:0]   mem_addr_o,
   output logic [7:0]             mem_wdata_o,
   output logic                   frm_valid_o,
   input  logic                   frm_ready_i,
   output logic [RX_BUF_AW-1:0]   frm_start_o,
   output rx_ptr_t                frm_len_o,
   output logic [DROP_CNT_W-1:0]  drop_cnt_o
);

   localparam int      AW       = RX_BUF_AW;
   localparam rx_ptr_t FULL_LVL = rx_ptr_t'(BUF_BYTES);
   localparam rx_ptr_t MAX_LEN  = rx_ptr_t'(MAX_FRAME_LEN);

   rx_wr_state_e           state_q, state_d;
   rx_ptr_t                wr_ptr_q, wr_ptr_d;
   rx_ptr_t                commit_q, commit_d;
   rx_ptr_t                len_q, len_d;
   rx_desc_t               desc_q, desc_d;
   logic [DROP_CNT_W-1:0]  drop_q, drop_d;
   logic                   tready_q, tready_d;
   logic                   mem_we_q, mem_we_d;
   logic [AW-1:0]          mem_addr_q, mem_addr_d;
   logic [7:0]             mem_wdata_q, mem_wdata_d;

   rx_ptr_t used;
   rx_ptr_t len_cur;
   rx_ptr_t len_inc;
   rx_ptr_t len_rep;
   logic    beat;
   logic    room;
   logic    too_short;
   logic    drop_evt;

   // Uncommitted bytes count as used, so a stalled frame cannot overrun the reader.
   assign used    = wr_ptr_q - rd_ptr_i;
   assign beat    = s_tvalid_i && tready_q;
   assign len_cur = (state_q == IDLE) ? '0 : len_q;
   assign len_inc = len_cur + rx_ptr_t'(1);
   assign room    = (used != FULL_LVL) && (len_cur < MAX_LEN);

`ifdef RX_FCS_STRIP_EN
   assign too_short = (len_inc <= rx_ptr_t'(RX_FCS_BYTES));
   assign len_rep   = len_inc - rx_ptr_t'(RX_FCS_BYTES);
`else
   assign too_short = 1'b0;
   assign len_rep   = len_inc;
`endif

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      commit_d    = commit_q;
      len_d       = len_q;
      desc_d      = desc_q;
      drop_d      = drop_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      drop_evt    = 1'b0;

      unique case (state_q)
         IDLE, WRITE: begin
            if (beat) begin
               if (state_q == IDLE) desc_d.start = commit_q[AW-1:0];
               if (room) begin
                  mem_we_d    = 1'b1;
                  mem_addr_d  = wr_ptr_q[AW-1:0];
                  mem_wdata_d = s_tdata_i;
                  wr_ptr_d    = wr_ptr_q + rx_ptr_t'(1);
                  len_d       = len_inc;
                  state_d     = WRITE;
               end else begin
                  wr_ptr_d = commit_q;
                  state_d  = DROP;
               end
               if (s_tlast_i) begin
                  if (!room || s_tuser_i || too_short) begin
                     drop_evt = 1'b1;
                     wr_ptr_d = commit_q;
                     state_d  = IDLE;
                  end else begin
                     desc_d.len = len_rep;
                     state_d    = POST;
                  end
               end
            end
         end
         DROP: begin
            if (beat && s_tlast_i) begin
               drop_evt = 1'b1;
               state_d  = IDLE;
            end
         end
         POST: begin
            if (frm_ready_i) begin
               commit_d = wr_ptr_q;
               state_d  = IDLE;
            end
         end
      endcase

      if (drop_evt && (drop_q != '1)) drop_d = drop_q + DROP_CNT_W'(1);
      // Registered ready: low in reset, then follows the next state.
      tready_d = (state_d != POST);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         commit_q    <= '0;
         len_q       <= '0;
         desc_q      <= '0;
         drop_q      <= '0;
         tready_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         commit_q    <= commit_d;
         len_q       <= len_d;
         desc_q      <= desc_d;
         drop_q      <= drop_d;
         tready_q    <= tready_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign s_tready_o  = tready_q;
   assign mem_en_o    = mem_we_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign frm_valid_o = (state_q == POST);
   assign frm_start_o = desc_q.start;
   assign frm_len_o   = desc_q.len;
   assign drop_cnt_o  = drop_q;

endmodule

// File: tb/tb_eth_rx_buf_writer.sv
// Scoreboard bench for eth_rx_buf_writer: expected writes and descriptors are queued
// from a reference model as beats are driven and compared as the DUT emits them.
module tb_eth_rx_buf_writer;
   import eth_rx_pkg::*;

   localparam int AW = RX_BUF_AW;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [7:0]    data;
   } wr_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [7:0]    s_tdata;
   logic          s_tvalid, s_tlast, s_tuser, frm_ready;
   rx_ptr_t       rd_ptr;
   logic          s_tready_o, mem_en_o, mem_we_o, frm_valid_o;
   logic [AW-1:0] mem_addr_o, frm_start_o;
   logic [7:0]    mem_wdata_o;
   rx_ptr_t       frm_len_o;
   logic [15:0]   drop_cnt_o;

   int n_chk = 0;
   int n_err = 0;

   wr_t      wq[$];
   rx_desc_t dq[$];
   rx_ptr_t  m_wr, m_commit;
   logic [15:0] m_drop;

   eth_rx_buf_writer dut (
      .clk_i(clk), .rst_ni(rst_n),
      .s_tdata_i(s_tdata), .s_tvalid_i(s_tvalid), .s_tlast_i(s_tlast), .s_tuser_i(s_tuser),
      .s_tready_o(s_tready_o), .rd_ptr_i(rd_ptr),
      .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .frm_valid_o(frm_valid_o), .frm_ready_i(frm_ready),
      .frm_start_o(frm_start_o), .frm_len_o(frm_len_o), .drop_cnt_o(drop_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && (mem_en_o || mem_we_o)) begin
         wr_t e;
         check("we_eq_en", 32'(mem_we_o), 32'(mem_en_o));
         if (wq.size() == 0) check("unexpected_write", 32'(mem_addr_o), 32'hFFFF);
         else begin
            e = wq.pop_front();
            check("wr_addr", 32'(mem_addr_o), 32'(e.addr));
            check("wr_data", 32'(mem_wdata_o), 32'(e.data));
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_tready", 32'(s_tready_o), 0);
      check("rst_mem_en", 32'(mem_en_o), 0);
      check("rst_mem_addr", 32'(mem_addr_o), 0);
      check("rst_frm_valid", 32'(frm_valid_o), 0);
      check("rst_frm_start", 32'(frm_start_o), 0);
      check("rst_frm_len", 32'(frm_len_o), 0);
      check("rst_drop_cnt", 32'(drop_cnt_o), 0);
      wq.delete();
      dq.delete();
      m_wr = '0; m_commit = '0; m_drop = '0; rd_ptr = '0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic send_frame(input int n, input bit tuser, input int hold, input bit ack,
                             output int stalls);
      bit       dropping = 1'b0;
      bit       good;
      int       cnt = 0;
      int       w;
      rx_ptr_t  used;
      rx_desc_t ed;
      wr_t      we;
      stalls   = 0;
      ed.start = m_commit[AW-1:0];
      ed.len   = '0;
      for (int i = 0; i < n; i++) begin
         s_tvalid = 1'b1;
         s_tdata  = 8'($urandom);
         s_tlast  = (i == n - 1);
         s_tuser  = (i == n - 1) ? tuser : 1'($urandom);
         w = 0;
         while (!s_tready_o && w < 50) begin w++; @(negedge clk); end
         stalls += w;
         if (!s_tready_o) begin check("tready_timeout", 0, 1); break; end
         if (!dropping) begin
            used = m_wr - rd_ptr;
            if (used != rx_ptr_t'(2048) && cnt < 1518) begin
               we.addr = m_wr[AW-1:0];
               we.data = s_tdata;
               wq.push_back(we);
               m_wr++;
               cnt++;
            end else begin
               dropping = 1'b1;
               m_wr     = m_commit;
            end
         end
         @(negedge clk);
      end
      s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
      good = !dropping && !tuser;
`ifdef RX_FCS_STRIP_EN
      good   = good && (cnt > 4);
      ed.len = rx_ptr_t'(cnt - 4);
`else
      ed.len = rx_ptr_t'(cnt);
`endif
      if (!good) begin
         m_wr = m_commit;
         if (m_drop != 16'hFFFF) m_drop++;
         check("no_desc", 32'(frm_valid_o), 0);
         check("drop_cnt", 32'(drop_cnt_o), 32'(m_drop));
         return;
      end
      dq.push_back(ed);
      w = 0;
      while (!frm_valid_o && w < 20) begin w++; @(negedge clk); end
      if (!frm_valid_o) begin check("desc_timeout", 0, 1); return; end
      check("desc_latency", 32'(w), 0);
      ed = dq.pop_front();
      check("desc_start", 32'(frm_start_o), 32'(ed.start));
      check("desc_len", 32'(frm_len_o), 32'(ed.len));
      check("post_tready", 32'(s_tready_o), 0);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check("hold_valid", 32'(frm_valid_o), 1);
         check("hold_tready", 32'(s_tready_o), 0);
         check("hold_start", 32'(frm_start_o), 32'(ed.start));
         check("hold_len", 32'(frm_len_o), 32'(ed.len));
      end
      if (!ack) return;
      frm_ready = 1'b1;
      @(negedge clk);
      frm_ready = 1'b0;
      check("valid_after_ack", 32'(frm_valid_o), 0);
      m_commit = m_wr;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int st;
      rst_n = 1'b0; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
      frm_ready = 1'b0; rd_ptr = '0;
      repeat (2) @(negedge clk);
      do_reset();

      send_frame(60, 1'b0, 0, 1'b1, st);
      send_frame(100, 1'b1, 0, 1'b1, st);
      send_frame(30, 1'b0, 0, 1'b1, st);
      rd_ptr = m_commit;
      send_frame(1500, 1'b0, 0, 1'b1, st);
      rd_ptr = m_commit;
      send_frame(450, 1'b0, 0, 1'b1, st);
      rd_ptr = m_commit;
      send_frame(20, 1'b0, 0, 1'b1, st);
      rd_ptr = m_commit;
      send_frame(4, 1'b0, 0, 1'b1, st);
      send_frame(5, 1'b0, 0, 1'b1, st);

      do_reset();
      send_frame(1000, 1'b0, 0, 1'b1, st);
      send_frame(1000, 1'b0, 0, 1'b1, st);
      send_frame(100, 1'b0, 0, 1'b1, st);
      check("full_drop_no_stall", 32'(st), 0);
      rd_ptr = m_commit;
      send_frame(10, 1'b0, 0, 1'b1, st);
      rd_ptr = m_commit;
      send_frame(1519, 1'b0, 0, 1'b1, st);
      send_frame(1518, 1'b0, 0, 1'b1, st);
      rd_ptr = m_commit;
      send_frame(60, 1'b0, 10, 1'b1, st);
      send_frame(40, 1'b0, 2, 1'b0, st);
      @(negedge clk);
      check("pre_reset_valid", 32'(frm_valid_o), 1);
      check("pre_reset_drops", 32'(drop_cnt_o), 32'(m_drop));
      do_reset();
      send_frame(8, 1'b0, 0, 1'b1, st);
      repeat (3) @(negedge clk);
      check("wq_empty", 32'(wq.size()), 0);
      check("dq_empty", 32'(dq.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
